// File: rtl/bridge_relay_v2.sv
// bridge_relay_v2: CMD <-> KMBox UART byte relay.
// Forward path (CMD RX -> KMBox TX) carries a FIFO, a registered TX stage and an
// atomic two-byte auto-ping injector. Return path (KMBox RX -> CMD TX) is a plain
// FIFO + registered TX stage. Also provides link-alive, activity LED, FIFO levels
// and saturating drop counters.
module bridge_relay_v2 #(
  parameter int         DEPTH_LOG2    = 4,
  parameter int         PING_INTERVAL = 96_000_000,
  parameter int         TIMEOUT_CLKS  = 240_000_000,
  parameter logic [7:0] PING_B0       = 8'hBD,
  parameter logic [7:0] PING_B1       = 8'hFE,
  parameter int         ACT_HOLD      = 255,
  parameter int         CNT_W         = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            cmd_rx_data,
  input  logic                  cmd_rx_valid,
  output logic [7:0]            cmd_tx_data,
  output logic                  cmd_tx_valid,
  input  logic                  cmd_tx_ready,
  input  logic [7:0]            kmbox_rx_data,
  input  logic                  kmbox_rx_valid,
  output logic [7:0]            kmbox_tx_data,
  output logic                  kmbox_tx_valid,
  input  logic                  kmbox_tx_ready,
  input  logic                  ping_en,
  input  logic                  stat_clr,
  output logic                  connected,
  output logic                  activity,
  output logic [DEPTH_LOG2:0]   fwd_level,
  output logic [DEPTH_LOG2:0]   ret_level,
  output logic [CNT_W-1:0]      fwd_drops,
  output logic [CNT_W-1:0]      ret_drops
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int PT_W  = (PING_INTERVAL > 0) ? $clog2(PING_INTERVAL + 1) : 1;
  localparam int TO_W  = (TIMEOUT_CLKS > 0) ? $clog2(TIMEOUT_CLKS + 1) : 1;
  localparam int AH_W  = (ACT_HOLD > 0) ? $clog2(ACT_HOLD + 1) : 1;

  localparam logic [PW-1:0]    DEPTH_L  = PW'(DEPTH);
  localparam logic [PT_W-1:0]  PING_MAX = PT_W'(PING_INTERVAL);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CLKS);
  localparam logic [AH_W-1:0]  ACT_MAX  = AH_W'(ACT_HOLD);

  // Ping sequencer states: P0 = sync byte in stage, P1 = ping cmd byte in stage.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_P0   = 2'd1;
  localparam logic [1:0] ST_P1   = 2'd2;

  // Next value of a saturating drop counter; a clear wins over the old count but
  // a drop in the same cycle still counts as one.
  function automatic logic [CNT_W-1:0] drop_next(input logic [CNT_W-1:0] cnt,
                                                 input logic drop, input logic clr);
    logic [CNT_W-1:0] nxt;
    if (clr) begin
      nxt = drop ? CNT_W'(1) : {CNT_W{1'b0}};
    end else if (drop && (cnt != {CNT_W{1'b1}})) begin
      nxt = cnt + CNT_W'(1);
    end else begin
      nxt = cnt;
    end
    return nxt;
  endfunction

  logic [7:0]      fwd_mem_r [DEPTH];
  logic [PW-1:0]   fwd_wr_r, fwd_rd_r;
  logic [7:0]      ret_mem_r [DEPTH];
  logic [PW-1:0]   ret_wr_r, ret_rd_r;
  logic [1:0]      state_r;
  logic [PT_W-1:0] ping_timer_r;
  logic [TO_W-1:0] conn_timer_r;
  logic [AH_W-1:0] act_cnt_r;

  logic fwd_full_s, fwd_empty_s, fwd_load_ok_s, fwd_pop_s, fwd_bypass_s, fwd_push_s, fwd_drop_s;
  logic ret_full_s, ret_empty_s, ret_load_ok_s, ret_pop_s, ret_bypass_s, ret_push_s, ret_drop_s;
  logic ping_start_s, ping_done_s;

  // Full/empty come from the registered level, i.e. the pre-cycle occupancy.
  assign fwd_full_s    = (fwd_level == DEPTH_L);
  assign fwd_empty_s   = (fwd_level == {PW{1'b0}});
  assign fwd_load_ok_s = !kmbox_tx_valid || kmbox_tx_ready;
  assign fwd_pop_s     = (state_r == ST_IDLE) && fwd_load_ok_s && !fwd_empty_s;
  // An RX byte with nothing queued skips the FIFO to get 1-cycle latency.
  assign fwd_bypass_s  = (state_r == ST_IDLE) && fwd_load_ok_s && fwd_empty_s && cmd_rx_valid;
  assign fwd_push_s    = cmd_rx_valid && !fwd_full_s && !fwd_bypass_s;
  assign fwd_drop_s    = cmd_rx_valid && fwd_full_s;

  assign ret_full_s    = (ret_level == DEPTH_L);
  assign ret_empty_s   = (ret_level == {PW{1'b0}});
  assign ret_load_ok_s = !cmd_tx_valid || cmd_tx_ready;
  assign ret_pop_s     = ret_load_ok_s && !ret_empty_s;
  assign ret_bypass_s  = ret_load_ok_s && ret_empty_s && kmbox_rx_valid;
  assign ret_push_s    = kmbox_rx_valid && !ret_full_s && !ret_bypass_s;
  assign ret_drop_s    = kmbox_rx_valid && ret_full_s;

  // Ping starts only on a quiet, fully drained forward path so it cannot split a byte stream.
  assign ping_start_s  = (state_r == ST_IDLE) && ping_en && (ping_timer_r >= PING_MAX) &&
                         fwd_empty_s && !kmbox_tx_valid && !cmd_rx_valid;
  assign ping_done_s   = (state_r == ST_P1) && kmbox_tx_valid && kmbox_tx_ready;

  // FIFO storage writes (contents need no reset; pointers define validity).
  always_ff @(posedge clk) begin
    if (fwd_push_s) fwd_mem_r[fwd_wr_r[DEPTH_LOG2-1:0]] <= cmd_rx_data;
    if (ret_push_s) ret_mem_r[ret_wr_r[DEPTH_LOG2-1:0]] <= kmbox_rx_data;
  end

  // FIFO pointers and registered occupancy for both directions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_wr_r  <= {PW{1'b0}};
      fwd_rd_r  <= {PW{1'b0}};
      fwd_level <= {PW{1'b0}};
      ret_wr_r  <= {PW{1'b0}};
      ret_rd_r  <= {PW{1'b0}};
      ret_level <= {PW{1'b0}};
    end else begin
      if (fwd_push_s) fwd_wr_r <= fwd_wr_r + PW'(1);
      if (fwd_pop_s)  fwd_rd_r <= fwd_rd_r + PW'(1);
      fwd_level <= fwd_level + PW'(fwd_push_s) - PW'(fwd_pop_s);
      if (ret_push_s) ret_wr_r <= ret_wr_r + PW'(1);
      if (ret_pop_s)  ret_rd_r <= ret_rd_r + PW'(1);
      ret_level <= ret_level + PW'(ret_push_s) - PW'(ret_pop_s);
    end
  end

  // Forward TX stage with ping sequencer; the stage only reloads when empty or on a transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      kmbox_tx_data  <= 8'h00;
      kmbox_tx_valid <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (ping_start_s) begin
            state_r        <= ST_P0;
            kmbox_tx_data  <= PING_B0;
            kmbox_tx_valid <= 1'b1;
          end else if (fwd_load_ok_s) begin
            if (!fwd_empty_s) begin
              kmbox_tx_data  <= fwd_mem_r[fwd_rd_r[DEPTH_LOG2-1:0]];
              kmbox_tx_valid <= 1'b1;
            end else if (cmd_rx_valid) begin
              kmbox_tx_data  <= cmd_rx_data;
              kmbox_tx_valid <= 1'b1;
            end else begin
              kmbox_tx_valid <= 1'b0;
            end
          end
        end
        ST_P0: begin
          if (kmbox_tx_valid && kmbox_tx_ready) begin
            state_r        <= ST_P1;
            kmbox_tx_data  <= PING_B1;
            kmbox_tx_valid <= 1'b1;
          end
        end
        ST_P1: begin
          // No pop on the completing cycle; queued CMD bytes resume next cycle.
          if (ping_done_s) begin
            state_r        <= ST_IDLE;
            kmbox_tx_valid <= 1'b0;
          end
        end
        default: begin
          state_r        <= ST_IDLE;
          kmbox_tx_valid <= 1'b0;
        end
      endcase
    end
  end

  // Return TX stage: plain FIFO/bypass relay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_tx_data  <= 8'h00;
      cmd_tx_valid <= 1'b0;
    end else if (ret_load_ok_s) begin
      if (!ret_empty_s) begin
        cmd_tx_data  <= ret_mem_r[ret_rd_r[DEPTH_LOG2-1:0]];
        cmd_tx_valid <= 1'b1;
      end else if (kmbox_rx_valid) begin
        cmd_tx_data  <= kmbox_rx_data;
        cmd_tx_valid <= 1'b1;
      end else begin
        cmd_tx_valid <= 1'b0;
      end
    end
  end

  // Ping silence timer: restarts on CMD traffic and after each ping, saturates at the interval.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ping_timer_r <= {PT_W{1'b0}};
    end else if (cmd_rx_valid || ping_done_s) begin
      ping_timer_r <= {PT_W{1'b0}};
    end else if (ping_timer_r < PING_MAX) begin
      ping_timer_r <= ping_timer_r + PT_W'(1);
    end
  end

  // Link-alive: any KMBox byte sets it; it drops on the cycle the silence timer reaches the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      connected    <= 1'b0;
      conn_timer_r <= {TO_W{1'b0}};
    end else if (kmbox_rx_valid) begin
      connected    <= 1'b1;
      conn_timer_r <= {TO_W{1'b0}};
    end else if (conn_timer_r < TO_MAX) begin
      conn_timer_r <= conn_timer_r + TO_W'(1);
      if (conn_timer_r == (TO_MAX - TO_W'(1))) connected <= 1'b0;
    end else begin
      connected <= 1'b0;
    end
  end

  // Activity LED hold counter and its registered output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_cnt_r <= {AH_W{1'b0}};
      activity  <= 1'b0;
    end else begin
      if (cmd_rx_valid || kmbox_rx_valid) begin
        act_cnt_r <= ACT_MAX;
      end else if (act_cnt_r != {AH_W{1'b0}}) begin
        act_cnt_r <= act_cnt_r - AH_W'(1);
      end
      activity <= (act_cnt_r != {AH_W{1'b0}});
    end
  end

  // Saturating drop counters with synchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_drops <= {CNT_W{1'b0}};
      ret_drops <= {CNT_W{1'b0}};
    end else begin
      fwd_drops <= drop_next(fwd_drops, fwd_drop_s, stat_clr);
      ret_drops <= drop_next(ret_drops, ret_drop_s, stat_clr);
    end
  end

endmodule

// File: tb/tb_bridge_relay_v2.sv
// Directed bench for bridge_relay_v2: relay latency, FIFO overflow, ping, link timeout,
// drop-counter clear and asynchronous reset mid-ping.
module tb_bridge_relay_v2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  cmd_rx_data = 8'h00;
  logic        cmd_rx_valid = 1'b0;
  logic [7:0]  cmd_tx_data;
  logic        cmd_tx_valid;
  logic        cmd_tx_ready = 1'b1;
  logic [7:0]  kmbox_rx_data = 8'h00;
  logic        kmbox_rx_valid = 1'b0;
  logic [7:0]  kmbox_tx_data;
  logic        kmbox_tx_valid;
  logic        kmbox_tx_ready = 1'b1;
  logic        ping_en = 1'b0;
  logic        stat_clr = 1'b0;
  logic        connected;
  logic        activity;
  logic [4:0]  fwd_level;
  logic [4:0]  ret_level;
  logic [15:0] fwd_drops;
  logic [15:0] ret_drops;

  int tests = 0;
  int fails = 0;

  bridge_relay_v2 #(
    .DEPTH_LOG2(4), .PING_INTERVAL(100), .TIMEOUT_CLKS(50),
    .PING_B0(8'hBD), .PING_B1(8'hFE), .ACT_HOLD(20), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_rx_data(cmd_rx_data), .cmd_rx_valid(cmd_rx_valid),
    .cmd_tx_data(cmd_tx_data), .cmd_tx_valid(cmd_tx_valid), .cmd_tx_ready(cmd_tx_ready),
    .kmbox_rx_data(kmbox_rx_data), .kmbox_rx_valid(kmbox_rx_valid),
    .kmbox_tx_data(kmbox_tx_data), .kmbox_tx_valid(kmbox_tx_valid), .kmbox_tx_ready(kmbox_tx_ready),
    .ping_en(ping_en), .stat_clr(stat_clr),
    .connected(connected), .activity(activity),
    .fwd_level(fwd_level), .ret_level(ret_level),
    .fwd_drops(fwd_drops), .ret_drops(ret_drops)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a KMBox TX byte with ready held high; returns it one cycle later.
  task automatic get_kbyte(output logic [7:0] b);
    b = 8'h00;
    for (int n = 0; n < 50; n++) begin
      if (kmbox_tx_valid === 1'b1) begin
        b = kmbox_tx_data;
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    check("kmbox_tx_wait", {31'd0, kmbox_tx_valid}, 32'd1);
  endtask

  task automatic cmd_strobe(input logic [7:0] d);
    @(negedge clk);
    cmd_rx_valid = 1'b1;
    cmd_rx_data  = d;
    @(negedge clk);
    cmd_rx_valid = 1'b0;
  endtask

  task automatic kmbox_strobe(input logic [7:0] d, input logic clr);
    @(negedge clk);
    kmbox_rx_valid = 1'b1;
    kmbox_rx_data  = d;
    stat_clr       = clr;
    @(negedge clk);
    kmbox_rx_valid = 1'b0;
    stat_clr       = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ktv"}, {31'd0, kmbox_tx_valid}, 32'd0);
    check({tag, "_ktd"}, {24'd0, kmbox_tx_data}, 32'd0);
    check({tag, "_ctv"}, {31'd0, cmd_tx_valid}, 32'd0);
    check({tag, "_ctd"}, {24'd0, cmd_tx_data}, 32'd0);
    check({tag, "_conn"}, {31'd0, connected}, 32'd0);
    check({tag, "_act"}, {31'd0, activity}, 32'd0);
    check({tag, "_flvl"}, {27'd0, fwd_level}, 32'd0);
    check({tag, "_rlvl"}, {27'd0, ret_level}, 32'd0);
    check({tag, "_fdrp"}, {16'd0, fwd_drops}, 32'd0);
    check({tag, "_rdrp"}, {16'd0, ret_drops}, 32'd0);
  endtask

  initial begin
    logic [7:0] b;
    int         viol;
    int         waited;

    // Reset state
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 1: single bytes, 1-cycle latency
    for (int i = 1; i <= 5; i++) begin
      cmd_strobe(8'(i));
      check("t1_valid", {31'd0, kmbox_tx_valid}, 32'd1);
      check("t1_data", {24'd0, kmbox_tx_data}, i);
      @(negedge clk);
      check("t1_drained", {31'd0, kmbox_tx_valid}, 32'd0);
      check("t1_activity", {31'd0, activity}, 32'd1);
      repeat (7) @(negedge clk);
    end

    // 2: overflow with stalled KMBox TX
    kmbox_tx_ready = 1'b0;
    for (int i = 0; i < 20; i++) cmd_strobe(8'h40 + 8'(i));
    check("t2_level", {27'd0, fwd_level}, 32'd16);
    check("t2_drops", {16'd0, fwd_drops}, 32'd3);
    check("t2_head", {24'd0, kmbox_tx_data}, 32'h40);
    kmbox_tx_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      get_kbyte(b);
      check("t2_order", {24'd0, b}, 32'h40 + k);
    end
    repeat (2) @(negedge clk);
    check("t2_empty", {27'd0, fwd_level}, 32'd0);
    check("t2_idle", {31'd0, kmbox_tx_valid}, 32'd0);

    // 4: ping disabled while idle
    kmbox_tx_ready = 1'b0;
    viol = 0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (kmbox_tx_valid !== 1'b0) viol++;
    end
    check("t4_no_ping", viol, 32'd0);
    check("t4_act_off", {31'd0, activity}, 32'd0);
    ping_en = 1'b1;
    @(negedge clk);
    check("t4_ping_start_v", {31'd0, kmbox_tx_valid}, 32'd1);
    check("t4_ping_b0", {24'd0, kmbox_tx_data}, 32'hBD);

    // 3: CMD byte during P0, stall in P1, byte follows FE
    cmd_strobe(8'h33);
    check("t3_queued", {27'd0, fwd_level}, 32'd1);
    check("t3_b0_held", {24'd0, kmbox_tx_data}, 32'hBD);
    kmbox_tx_ready = 1'b1;
    @(negedge clk);
    kmbox_tx_ready = 1'b0;
    check("t3_b1_v", {31'd0, kmbox_tx_valid}, 32'd1);
    check("t3_b1", {24'd0, kmbox_tx_data}, 32'hFE);
    repeat (5) @(negedge clk);
    check("t3_b1_stall_v", {31'd0, kmbox_tx_valid}, 32'd1);
    check("t3_b1_stall", {24'd0, kmbox_tx_data}, 32'hFE);
    kmbox_tx_ready = 1'b1;
    get_kbyte(b);
    check("t3_seq_fe", {24'd0, b}, 32'hFE);
    get_kbyte(b);
    check("t3_seq_33", {24'd0, b}, 32'h33);
    ping_en = 1'b0;

    // 5: connected timeout and restart, plus return relay latency
    check("t5_conn_init", {31'd0, connected}, 32'd0);
    kmbox_strobe(8'hA5, 1'b0);
    check("t5_conn_set", {31'd0, connected}, 32'd1);
    check("t5_ret_v", {31'd0, cmd_tx_valid}, 32'd1);
    check("t5_ret_d", {24'd0, cmd_tx_data}, 32'hA5);
    repeat (49) @(negedge clk);
    check("t5_conn_49", {31'd0, connected}, 32'd1);
    @(negedge clk);
    check("t5_conn_50", {31'd0, connected}, 32'd0);
    kmbox_strobe(8'h5A, 1'b0);
    repeat (29) @(negedge clk);
    kmbox_strobe(8'h5B, 1'b0);
    repeat (49) @(negedge clk);
    check("t5_restart_49", {31'd0, connected}, 32'd1);
    @(negedge clk);
    check("t5_restart_50", {31'd0, connected}, 32'd0);

    // 6: return overflow and drop coincident with stat_clr
    cmd_tx_ready = 1'b0;
    for (int i = 0; i < 17; i++) kmbox_strobe(8'h60 + 8'(i), 1'b0);
    check("t6_level", {27'd0, ret_level}, 32'd16);
    check("t6_no_drop", {16'd0, ret_drops}, 32'd0);
    check("t6_head", {24'd0, cmd_tx_data}, 32'h60);
    kmbox_strobe(8'h71, 1'b0);
    kmbox_strobe(8'h72, 1'b0);
    check("t6_drops2", {16'd0, ret_drops}, 32'd2);
    kmbox_strobe(8'h73, 1'b1);
    check("t6_clr_drop", {16'd0, ret_drops}, 32'd1);
    check("t6_clr_fwd", {16'd0, fwd_drops}, 32'd0);

    // 6: async reset in the middle of a ping
    ping_en = 1'b1;
    kmbox_tx_ready = 1'b0;
    waited = 0;
    while (kmbox_tx_valid !== 1'b1 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    check("t6_ping_v", {31'd0, kmbox_tx_valid}, 32'd1);
    check("t6_ping_b0", {24'd0, kmbox_tx_data}, 32'hBD);
    kmbox_tx_ready = 1'b1;
    @(negedge clk);
    kmbox_tx_ready = 1'b0;
    check("t6_ping_b1", {24'd0, kmbox_tx_data}, 32'hFE);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    @(negedge clk);
    ping_en = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ktv", {31'd0, kmbox_tx_valid}, 32'd0);
    check("post_rst_rlvl", {27'd0, ret_level}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
